int_alu_pipe: RTL



---
 rtl/int_alu_pipe.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/int_alu_pipe.sv
// Two-stage, multi-lane integer ALU between operand collect and writeback.
// Stage 1 registers gated operands and partial products; stage 2 is the output register.
module int_alu_pipe #(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int TAG_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_op,
  input  logic                   in_signed,
  input  logic [LANES-1:0]       in_mask,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic [LANES*WIDTH-1:0] in_c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_y,
  output logic [LANES-1:0]       out_mask,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_illegal
);

  localparam int S = $clog2(WIDTH);

  // Widths are at most 64, so a two-copy pattern covers both truncation and replication.
  localparam logic [63:0]      ILL64   = {2{32'hDEADDEAD}};
  localparam logic [WIDTH-1:0] ILL_PAT = ILL64[WIDTH-1:0];

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_MUL = 4'd2,  OP_MAD = 4'd3,
    OP_SHL = 4'd4,  OP_SHR = 4'd5,  OP_AND = 4'd6,  OP_OR  = 4'd7,
    OP_XOR = 4'd8,  OP_MIN = 4'd9,  OP_MAX = 4'd10, OP_SLT = 4'd11
  } op_e;

  logic adv;

  // Stage 1 state
  logic                         s1_valid_q;
  logic [3:0]                   s1_op_q;
  logic                         s1_signed_q;
  logic [LANES-1:0]             s1_mask_q;
  logic [TAG_W-1:0]             s1_tag_q;
  logic                         s1_illegal_q;
  logic [LANES-1:0][WIDTH-1:0]  s1_a_q, s1_b_q, s1_c_q, s1_prod_q;

  // Stage 1 next-state
  logic [LANES-1:0][WIDTH-1:0]  a_d, b_d, c_d, prod_d;

  // Stage 2 state and next-state
  logic                         out_valid_q;
  logic [LANES-1:0][WIDTH-1:0]  out_y_q, y_d;
  logic [LANES-1:0]             out_mask_q;
  logic [TAG_W-1:0]             out_tag_q;
  logic                         out_illegal_q;
  logic [LANES-1:0]             lt;

  // The whole pipe moves as one; in_ready must never look at in_valid.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // Inactive lanes are gated to zero so the multipliers see no toggling.
  always_comb begin
    a_d    = '0;
    b_d    = '0;
    c_d    = '0;
    prod_d = '0;
    for (int l = 0; l < LANES; l++) begin
      if (in_mask[l]) begin
        a_d[l] = in_a[l*WIDTH +: WIDTH];
        b_d[l] = in_b[l*WIDTH +: WIDTH];
        c_d[l] = in_c[l*WIDTH +: WIDTH];
      end
      prod_d[l] = a_d[l] * b_d[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
    end
  end

  // NOTE: stage-1 datapath registers are not reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_op_q      <= in_op;
      s1_signed_q  <= in_signed;
      s1_mask_q    <= in_mask;
      s1_tag_q     <= in_tag;
      s1_illegal_q <= (in_op > OP_SLT);
      s1_a_q       <= a_d;
      s1_b_q       <= b_d;
      s1_c_q       <= c_d;
      s1_prod_q    <= prod_d;
    end
  end

  always_comb begin
    lt = '0;
    for (int l = 0; l < LANES; l++) begin
      lt[l] = s1_signed_q ? ($signed(s1_a_q[l]) < $signed(s1_b_q[l]))
                          : (s1_a_q[l] < s1_b_q[l]);
    end
  end

  always_comb begin
    y_d = '0;
    for (int l = 0; l < LANES; l++) begin
      case (s1_op_q)
        OP_ADD:  y_d[l] = s1_a_q[l] + s1_b_q[l];
        OP_SUB:  y_d[l] = s1_a_q[l] - s1_b_q[l];
        OP_MUL:  y_d[l] = s1_prod_q[l];
        OP_MAD:  y_d[l] = s1_prod_q[l] + s1_c_q[l];
        OP_SHL:  y_d[l] = s1_a_q[l] << s1_b_q[l][S-1:0];
        OP_SHR:  y_d[l] = s1_signed_q ? WIDTH'($signed(s1_a_q[l]) >>> s1_b_q[l][S-1:0])
                                      : (s1_a_q[l] >> s1_b_q[l][S-1:0]);
        OP_AND:  y_d[l] = s1_a_q[l] & s1_b_q[l];
        OP_OR:   y_d[l] = s1_a_q[l] | s1_b_q[l];
        OP_XOR:  y_d[l] = s1_a_q[l] ^ s1_b_q[l];
        OP_MIN:  y_d[l] = lt[l] ? s1_a_q[l] : s1_b_q[l];
        OP_MAX:  y_d[l] = lt[l] ? s1_b_q[l] : s1_a_q[l];
        OP_SLT:  y_d[l] = {{(WIDTH-1){1'b0}}, lt[l]};
        default: y_d[l] = ILL_PAT;
      endcase
      if (!s1_mask_q[l]) begin
        y_d[l] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_y_q       <= '0;
      out_mask_q    <= '0;
      out_tag_q     <= '0;
      out_illegal_q <= 1'b0;
    end else if (adv) begin
      out_valid_q   <= s1_valid_q;
      out_y_q       <= y_d;
      out_mask_q    <= s1_mask_q;
      out_tag_q     <= s1_tag_q;
      out_illegal_q <= s1_illegal_q;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_y       = out_y_q;
  assign out_mask    = out_mask_q;
  assign out_tag     = out_tag_q;
  assign out_illegal = out_illegal_q;

endmodule
